con_bus_arbiter: RTL and testbench
==================================

Name: con_bus_arbiter

Overview:
- Shares the single half-duplex external con bus between two users:
  - the load path: kernel and input words requested by the controller FSM;
  - the result drain path: tagged output words produced by the ODS.
- Buffers datapath results in a small tagged FIFO.
- Chooses bus direction by FIFO pressure, load lock and burst limits, and inserts turnaround cycles on every direction change.
- Sits between controller_fsm/ODS and the top-level con interface, and drives the bus direction signal.

Parameters:
- DATA_WIDTH, 16, width of one result word
- FIFO_DEPTH, 8, result FIFO entries; power of 2, at least 2
- HIGH_WATER, 6, FIFO occupancy that forces the bus to output direction; 1 to FIFO_DEPTH
- MAX_OUT_BURST, 4, maximum drained beats per output tenure while ld_req is pending; at least 1
- TURNAROUND_CYCLES, 1, idle cycles on each direction change; 1 to 7

Ports:
- clk  in  1  clock
- arst_n_in  in  1  reset, asynchronous, active-low
- ld_req  in  1  controller wants to receive load words
- ld_lock  in  1  controller is inside an atomic load sequence (e.g. the 12 kernel beats); direction must not leave LOAD
- ld_grant  out  1  bus is in load direction; controller may assert con_ready
- res_valid  in  1  datapath result valid
- res_ready  out  1  result FIFO can accept
- res_data  in  DATA_WIDTH  result value
- res_x, res_y, res_ch  in  32 each  result tags
- bus_dir  out  1  1 = device drives the bus
- bus_out_valid  out  1  FIFO head presented to host
- bus_out_ready  in  1  host accepts
- bus_out_data  out  DATA_WIDTH  head data
- bus_out_x, bus_out_y, bus_out_ch  out  32 each  head tags
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values: state LOAD, FIFO empty, fifo_level 0, burst counter 0, turnaround counter 0.
  - ld_grant = 1, bus_dir = 0, bus_out_valid = 0, res_ready = 1, all data and tag outputs 0.
- FIFO:
  - Push when res_valid && res_ready; pop when bus_out_valid && bus_out_ready.
  - res_ready = !full. It is registered-occupancy based, so a pop in the same cycle does not allow a push into a full FIFO.
  - Simultaneous push and pop leaves level unchanged. Pointers wrap modulo FIFO_DEPTH.
  - First-word fall-through: the head is visible the cycle after the push.
- States:
  - LOAD: ld_grant = 1, bus_dir = 0.
    - Go to TURN_OUT when !ld_lock && (level >= HIGH_WATER || (!ld_req && level > 0)).
    - With ld_lock high, stay in LOAD even if the FIFO is full; the datapath stalls on res_ready.
  - TURN_OUT: ld_grant = 0, bus_dir = 0, bus_out_valid = 0.
    - Stay TURNAROUND_CYCLES cycles, then go to OUT and clear the burst counter.
  - OUT: bus_dir = 1, bus_out_valid = !empty.
    - Burst counter increments on each accepted beat and saturates at MAX_OUT_BURST.
    - Once bus_out_valid is high, it and the head data/tags are held stable until accepted.
    - Go to TURN_LOAD when:
      - the FIFO is empty with no beat pending; or
      - an accepted beat brings the burst count to MAX_OUT_BURST while ld_req && level_after_pop < HIGH_WATER.
  - TURN_LOAD: ld_grant = 0, bus_dir = 0, bus_out_valid = 0.
    - Stay TURNAROUND_CYCLES cycles, then go to LOAD.
- ld_req low in LOAD while the FIFO is empty: remain in LOAD and idle.
- Turnaround and burst counters are 3 bits, compared against the parameters.
- ld_grant and bus_dir are never both 1. bus_dir changes only through a TURN state.
- Asynchronous reset mid-operation: returns immediately to reset values and discards FIFO contents. Pending host beats are lost.
- Illegal state encodings recover to LOAD.

Decomposition:
- Package con_bus_pkg holds:
  - typedef enum {LOAD, TURN_OUT, OUT, TURN_LOAD} con_bus_state_t;
  - packed struct res_entry_t {data, x, y, ch}.
- Sub-module tagged_fifo (parameters WIDTH and DEPTH; push/pop, full, empty, level) stores res_entry_t.
- The arbiter FSM lives in con_bus_arbiter.

Test Plan:
- Reset, then ld_req = 1 with no results: ld_grant = 1 and bus_dir = 0 held for 20 cycles; bus_out_valid never asserted.
- ld_req = 1 and ld_lock = 0, push 6 results (x = 0..5, ch = 0): at level 6, one TURN_OUT cycle with ld_grant = 0, then OUT.
  - Host always ready: exactly 4 beats x = 0..3 in order, one TURN_LOAD cycle, then ld_grant = 1.
  - Remaining level is 2.
- ld_lock = 1 with 9 pushes attempted: res_ready drops after the 8th; state stays LOAD.
  - Drop ld_lock: TURN_OUT, then all 8 drain in order (ld_req = 0).
- Host applies bus_out_ready = 0 for 3 cycles on the first beat: bus_out_valid and the data/tags stay stable; no state change; beat accepted on the 4th cycle.
- Simultaneous push and pop at level 3 for 5 cycles: level stays 3; output order matches push order across pointer wrap.
- Assert arst_n_in low mid-OUT with level 5: next edge shows fifo_level = 0, bus_dir = 0, ld_grant = 1, bus_out_valid = 0.

Source files
------------

// File: rtl/con_bus_pkg.sv
// Shared types for the con bus arbiter: FSM state encoding and the tagged result entry.
package con_bus_pkg;

   localparam int CON_DATA_W = 16;
   localparam int TAG_W      = 32;

   typedef enum logic [1:0] {
      LOAD      = 2'd0,
      TURN_OUT  = 2'd1,
      OUT       = 2'd2,
      TURN_LOAD = 2'd3
   } con_bus_state_t;

   typedef struct packed {
      logic [CON_DATA_W-1:0] data;
      logic [TAG_W-1:0]      x;
      logic [TAG_W-1:0]      y;
      logic [TAG_W-1:0]      ch;
   } res_entry_t;

endpackage

// File: rtl/con_bus_arbiter_fifo.sv
// First-word fall-through FIFO holding tagged result entries; occupancy is a registered count.
module tagged_fifo #(
   parameter int WIDTH = 112,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       arst_n_in,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage is not reset; the arbiter masks the head whenever it is not valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/con_bus_arbiter.sv
// Half-duplex con bus arbiter: load words in, tagged results out, with turnaround gaps between directions.
module con_bus_arbiter
   import con_bus_pkg::*;
#(
   parameter int DATA_WIDTH        = CON_DATA_W,
   parameter int FIFO_DEPTH        = 8,
   parameter int HIGH_WATER        = 6,
   parameter int MAX_OUT_BURST     = 4,
   parameter int TURNAROUND_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          arst_n_in,
   input  logic                          ld_req,
   input  logic                          ld_lock,
   output logic                          ld_grant,
   input  logic                          res_valid,
   output logic                          res_ready,
   input  logic [DATA_WIDTH-1:0]         res_data,
   input  logic [31:0]                   res_x,
   input  logic [31:0]                   res_y,
   input  logic [31:0]                   res_ch,
   output logic                          bus_dir,
   output logic                          bus_out_valid,
   input  logic                          bus_out_ready,
   output logic [DATA_WIDTH-1:0]         bus_out_data,
   output logic [31:0]                   bus_out_x,
   output logic [31:0]                   bus_out_y,
   output logic [31:0]                   bus_out_ch,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   con_bus_state_t state;
   res_entry_t     wr_entry;
   res_entry_t     head;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic [2:0]     turn_cnt;
   logic [2:0]     burst_cnt;
   logic [2:0]     burst_inc;
   logic [LW-1:0]  level_after_pop;
   logic           turn_done;
   logic           burst_yield;

   assign wr_entry = '{data: CON_DATA_W'(res_data), x: res_x, y: res_y, ch: res_ch};
   assign res_ready     = !full;
   assign push          = res_valid && !full;
   assign bus_out_valid = (state == OUT) && !empty;
   assign pop           = bus_out_valid && bus_out_ready;

   tagged_fifo #(
      .WIDTH ($bits(res_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .push      (push),
      .pop       (pop),
      .wdata     (wr_entry),
      .rdata     (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   // Head is only exposed while a beat is offered, so outputs read zero after reset.
   assign bus_out_data = bus_out_valid ? DATA_WIDTH'(head.data) : '0;
   assign bus_out_x    = bus_out_valid ? head.x  : '0;
   assign bus_out_y    = bus_out_valid ? head.y  : '0;
   assign bus_out_ch   = bus_out_valid ? head.ch : '0;

   assign turn_done       = (turn_cnt == 3'(TURNAROUND_CYCLES - 1));
   assign burst_inc       = (burst_cnt == 3'(MAX_OUT_BURST)) ? burst_cnt : burst_cnt + 3'd1;
   assign level_after_pop = fifo_level - LW'(1);
   assign burst_yield     = pop && (burst_inc == 3'(MAX_OUT_BURST)) && ld_req &&
                            (level_after_pop < LW'(HIGH_WATER));

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state     <= LOAD;
         ld_grant  <= 1'b1;
         bus_dir   <= 1'b0;
         turn_cnt  <= 3'd0;
         burst_cnt <= 3'd0;
      end else begin
         case (state)
            LOAD: begin
               if (!ld_lock && ((fifo_level >= LW'(HIGH_WATER)) || (!ld_req && !empty))) begin
                  state    <= TURN_OUT;
                  ld_grant <= 1'b0;
                  turn_cnt <= 3'd0;
               end
            end
            TURN_OUT: begin
               if (turn_done) begin
                  state     <= OUT;
                  bus_dir   <= 1'b1;
                  burst_cnt <= 3'd0;
                  turn_cnt  <= 3'd0;
               end else begin
                  turn_cnt <= turn_cnt + 3'd1;
               end
            end
            OUT: begin
               if (pop) burst_cnt <= burst_inc;
               // An empty FIFO means no beat is offered, so leaving cannot strand a handshake.
               if (burst_yield || empty) begin
                  state    <= TURN_LOAD;
                  bus_dir  <= 1'b0;
                  turn_cnt <= 3'd0;
               end
            end
            TURN_LOAD: begin
               if (turn_done) begin
                  state    <= LOAD;
                  ld_grant <= 1'b1;
                  turn_cnt <= 3'd0;
               end else begin
                  turn_cnt <= turn_cnt + 3'd1;
               end
            end
            default: begin
               state     <= LOAD;
               ld_grant  <= 1'b1;
               bus_dir   <= 1'b0;
               turn_cnt  <= 3'd0;
               burst_cnt <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_con_bus_arbiter.sv
// Directed bench for con_bus_arbiter: load hold, burst drain, lock/full, stall, wrap and async reset.
module tb_con_bus_arbiter;

   logic        clk;
   logic        arst_n_in;
   logic        ld_req;
   logic        ld_lock;
   logic        ld_grant;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [31:0] res_x;
   logic [31:0] res_y;
   logic [31:0] res_ch;
   logic        bus_dir;
   logic        bus_out_valid;
   logic        bus_out_ready;
   logic [15:0] bus_out_data;
   logic [31:0] bus_out_x;
   logic [31:0] bus_out_y;
   logic [31:0] bus_out_ch;
   logic [3:0]  fifo_level;

   int checks   = 0;
   int failures = 0;

   con_bus_arbiter dut (
      .clk           (clk),
      .arst_n_in     (arst_n_in),
      .ld_req        (ld_req),
      .ld_lock       (ld_lock),
      .ld_grant      (ld_grant),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_x         (res_x),
      .res_y         (res_y),
      .res_ch        (res_ch),
      .bus_dir       (bus_dir),
      .bus_out_valid (bus_out_valid),
      .bus_out_ready (bus_out_ready),
      .bus_out_data  (bus_out_data),
      .bus_out_x     (bus_out_x),
      .bus_out_y     (bus_out_y),
      .bus_out_ch    (bus_out_ch),
      .fifo_level    (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int x);
      res_valid = 1'b1;
      res_x     = 32'(x);
      res_y     = 32'(x + 1000);
      res_ch    = 32'd0;
      res_data  = 16'(32'h100 + x);
      step();
      res_valid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input int x);
      chk({tag, "_valid"}, bus_out_valid, 1'b1);
      chk({tag, "_x"}, bus_out_x, 32'(x));
      chk({tag, "_data"}, bus_out_data, 32'(16'(32'h100 + x)));
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (bus_dir !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk(tag, bus_dir, 1'b1);
   endtask

   task automatic wait_load(input string tag);
      int n = 0;
      while (ld_grant !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk(tag, ld_grant, 1'b1);
   endtask

   initial begin
      logic hold_ok;
      arst_n_in     = 1'b0;
      ld_req        = 1'b0;
      ld_lock       = 1'b0;
      res_valid     = 1'b0;
      res_data      = '0;
      res_x         = '0;
      res_y         = '0;
      res_ch        = '0;
      bus_out_ready = 1'b1;
      repeat (2) step();

      chk("rst_grant", ld_grant, 1'b1);
      chk("rst_dir", bus_dir, 1'b0);
      chk("rst_valid", bus_out_valid, 1'b0);
      chk("rst_ready", res_ready, 1'b1);
      chk("rst_level", fifo_level, 4'd0);
      chk("rst_data", bus_out_data, 16'd0);
      chk("rst_x", bus_out_x, 32'd0);
      arst_n_in = 1'b1;

      // Idle load direction with no results
      ld_req  = 1'b1;
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ld_grant !== 1'b1 || bus_dir !== 1'b0 || bus_out_valid !== 1'b0) hold_ok = 1'b0;
      end
      chk("idle_hold", hold_ok, 1'b1);

      // High-water turn and burst limit
      for (int i = 0; i < 6; i++) push(i);
      chk("hw_level", fifo_level, 4'd6);
      chk("hw_still_load", ld_grant, 1'b1);
      step();
      chk("turn_out_grant", ld_grant, 1'b0);
      chk("turn_out_dir", bus_dir, 1'b0);
      chk("turn_out_valid", bus_out_valid, 1'b0);
      step();
      chk("out_dir", bus_dir, 1'b1);
      for (int i = 0; i < 4; i++) begin
         expect_beat("burst", i);
         step();
      end
      chk("turn_load_dir", bus_dir, 1'b0);
      chk("turn_load_grant", ld_grant, 1'b0);
      chk("turn_load_valid", bus_out_valid, 1'b0);
      step();
      chk("back_load_grant", ld_grant, 1'b1);
      chk("remain_level", fifo_level, 4'd2);

      // Drain leftovers with ld_req low
      ld_req = 1'b0;
      wait_out("drain_out");
      expect_beat("left", 4);
      chk("left_y", bus_out_y, 32'd1004);
      step();
      expect_beat("left", 5);
      step();
      chk("left_empty_valid", bus_out_valid, 1'b0);
      wait_load("drain_back");
      chk("drain_level", fifo_level, 4'd0);

      // Locked load fills the FIFO; ninth push refused
      ld_lock = 1'b1;
      ld_req  = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk("lock_ready", res_ready, (i < 8) ? 1'b1 : 1'b0);
         push(10 + i);
      end
      chk("lock_level", fifo_level, 4'd8);
      repeat (3) step();
      chk("lock_grant", ld_grant, 1'b1);
      chk("lock_dir", bus_dir, 1'b0);
      chk("lock_full_ready", res_ready, 1'b0);

      // Unlock and drain all eight, first beat stalled by host
      bus_out_ready = 1'b0;
      ld_lock       = 1'b0;
      ld_req        = 1'b0;
      step();
      chk("unlock_turn_grant", ld_grant, 1'b0);
      chk("unlock_turn_dir", bus_dir, 1'b0);
      step();
      chk("unlock_out_dir", bus_dir, 1'b1);
      for (int i = 0; i < 3; i++) begin
         expect_beat("stall", 10);
         chk("stall_level", fifo_level, 4'd8);
         chk("stall_dir", bus_dir, 1'b1);
         step();
      end
      bus_out_ready = 1'b1;
      expect_beat("stall_accept", 10);
      step();
      for (int i = 1; i < 8; i++) begin
         expect_beat("full_drain", 10 + i);
         step();
      end
      chk("full_drain_empty", bus_out_valid, 1'b0);
      wait_load("full_drain_back");

      // Concurrent push/pop at level 3 across pointer wrap
      ld_lock = 1'b1;
      for (int i = 0; i < 3; i++) push(20 + i);
      ld_lock = 1'b0;
      ld_req  = 1'b0;
      wait_out("wrap_out");
      for (int i = 0; i < 5; i++) begin
         res_valid = 1'b1;
         res_x     = 32'(23 + i);
         res_y     = 32'(1023 + i);
         res_ch    = 32'd0;
         res_data  = 16'(32'h100 + 23 + i);
         chk("wrap_level", fifo_level, 4'd3);
         expect_beat("wrap", 20 + i);
         step();
      end
      res_valid = 1'b0;
      chk("wrap_level_end", fifo_level, 4'd3);
      for (int i = 0; i < 3; i++) begin
         expect_beat("wrap_tail", 25 + i);
         step();
      end
      wait_load("wrap_back");

      // Asynchronous reset in the middle of an output tenure
      ld_lock = 1'b1;
      for (int i = 0; i < 5; i++) push(30 + i);
      bus_out_ready = 1'b0;
      ld_lock       = 1'b0;
      ld_req        = 1'b0;
      wait_out("arst_pre_out");
      chk("arst_pre_level", fifo_level, 4'd5);
      #2;
      arst_n_in = 1'b0;
      #1;
      chk("arst_async_level", fifo_level, 4'd0);
      chk("arst_async_dir", bus_dir, 1'b0);
      step();
      chk("arst_level", fifo_level, 4'd0);
      chk("arst_dir", bus_dir, 1'b0);
      chk("arst_grant", ld_grant, 1'b1);
      chk("arst_valid", bus_out_valid, 1'b0);
      chk("arst_x", bus_out_x, 32'd0);
      arst_n_in = 1'b1;
      step();
      chk("post_arst_ready", res_ready, 1'b1);
      chk("post_arst_grant", ld_grant, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
